// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and constants for the reg_file_sb register file.
//   rf_state_t : sequencer state (CLEAR sweep, READY for normal operation)
//   DEF_*      : default register width / address width
//   port_off() : bit offset of a read port's field in a packed bus
package reg_file_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Offset of port `port` inside a packed bus of `width`-bit fields.
    function automatic int port_off(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits for hazard detection.
// Ports:
//   clk, rst             clock, asynchronous active-high reset (clears all bits)
//   enable               high when the register file accepts writes/issues
//   set_busy, set_addr   issue of a new producer for set_addr
//   clr0, clr0_addr      write port 0 activity (clears busy)
//   clr1, clr1_addr      write port 1 activity (clears busy)
//   busy                 current busy vector, bit 0 is always 0
module rf_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 set_busy,
    input  logic [ADDR_W-1:0]    set_addr,
    input  logic                 clr0,
    input  logic [ADDR_W-1:0]    clr0_addr,
    input  logic                 clr1,
    input  logic [ADDR_W-1:0]    clr1_addr,
    output logic [2**ADDR_W-1:0] busy
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;

    // Register 0 is hardwired to zero, so it can never carry a hazard.
    assign busy_next[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_bit
            logic hit_set;
            logic hit_clr;
            assign hit_set = enable && set_busy && (set_addr == ADDR_W'(gi));
            assign hit_clr = enable && ((clr0 && (clr0_addr == ADDR_W'(gi))) ||
                                        (clr1 && (clr1_addr == ADDR_W'(gi))));
            // A newly issued producer outranks a retiring one on the same register.
            assign busy_next[gi] = hit_set | (busy_reg[gi] & ~hit_clr);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy = busy_reg;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised multi-read, dual-write register file with
// same-cycle write bypass, busy scoreboard and a post-reset clear sweep.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   init_done           high once every entry has been zeroed
//   ra / rd / rd_busy   NRD packed read ports (combinational, bypassed)
//   we0/wa0/wd0         write port 0 (ALU writeback)
//   we1/wa1/wd1         write port 1 (load return, wins on address clash)
//   set_busy/set_addr   mark a destination register busy at issue
//   dbg_addr/dbg_data   array-only debug read (no bypass)
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NRD    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*DATA_W-1:0] rd,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     wa0,
    input  logic [DATA_W-1:0]     wd0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     wa1,
    input  logic [DATA_W-1:0]     wd1,
    input  logic                  set_busy,
    input  logic [ADDR_W-1:0]     set_addr,
    input  logic [ADDR_W-1:0]     dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    localparam int DEPTH = 2**ADDR_W;

    rf_state_t         state_reg;
    rf_state_t         state_next;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic [ADDR_W-1:0] clr_cnt_next;

    logic [DATA_W-1:0] rf [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              ready;
    logic              wr0_ok;
    logic              wr1_ok;

    // Clear sequencer: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // Clear sequencer: next state. One entry is zeroed per cycle.
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            CLEAR: begin
                clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
                if (clr_cnt_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = READY;
                end
            end
            READY: begin
                state_next = READY;
            end
        endcase
    end

    assign ready     = (state_reg == READY);
    assign init_done = ready;

    // Port 0 yields to port 1 when both target the same register.
    assign wr1_ok = ready && we1 && (wa1 != '0);
    assign wr0_ok = ready && we0 && (wa0 != '0) && !(we1 && (wa1 == wa0));

    // Storage array: no reset, contents are zeroed by the sweep instead.
    always_ff @(posedge clk) begin
        if (!ready) begin
            rf[clr_cnt_reg] <= '0;
        end else begin
            if (wr0_ok) begin
                rf[wa0] <= wd0;
            end
            if (wr1_ok) begin
                rf[wa1] <= wd1;
            end
        end
    end

    rf_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .enable    (ready),
        .set_busy  (set_busy),
        .set_addr  (set_addr),
        .clr0      (we0),
        .clr0_addr (wa0),
        .clr1      (we1),
        .clr1_addr (wa1),
        .busy      (busy)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              hit1;
            logic              hit0;
            logic [DATA_W-1:0] data;

            assign addr = ra[port_off(gi, ADDR_W) +: ADDR_W];
            assign hit1 = we1 && (wa1 == addr);
            assign hit0 = we0 && (wa0 == addr);

            always_comb begin
                data = '0;
                if (ready && (addr != '0)) begin
                    if (hit1) begin
                        data = wd1;
                    end else if (hit0) begin
                        data = wd0;
                    end else begin
                        data = rf[addr];
                    end
                end
            end

            assign rd[port_off(gi, DATA_W) +: DATA_W] = data;
            // A write landing this cycle resolves the hazard without a stall.
            assign rd_busy[gi] = ready && busy[addr] && !(hit1 || hit0);
        end
    endgenerate

    assign dbg_data = (ready && (dbg_addr != '0)) ? rf[dbg_addr] : '0;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: self-checking bench for reg_file_sb. A default-sized
// instance is checked every cycle against a behavioural model; a second
// instance (NRD=4, DATA_W=64, ADDR_W=4) covers sweep length and 4-port bypass.
module tb_reg_file_sb;

    localparam int DEPTH = 32;

    logic        clk;
    logic        rst;
    logic        init_done;
    logic [14:0] ra;
    logic [95:0] rd;
    logic [2:0]  rd_busy;
    logic        we0, we1, set_busy;
    logic [4:0]  wa0, wa1, set_addr, dbg_addr;
    logic [31:0] wd0, wd1, dbg_data;

    logic         rst2, init_done2;
    logic [15:0]  ra2;
    logic [255:0] rd2;
    logic [3:0]   rd_busy2;
    logic         we0_2, we1_2, set_busy2;
    logic [3:0]   wa0_2, wa1_2, set_addr2, dbg_addr2;
    logic [63:0]  wd0_2, wd1_2, dbg_data2;

    int n_checks = 0;
    int n_errors = 0;
    int n_cyc    = 0;

    // Reference model: what the register file should hold, at spec level.
    logic [31:0] m_mem [DEPTH];
    bit          m_busy [DEPTH];
    bit          m_ready;
    int          m_cnt;

    reg_file_sb dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .ra(ra), .rd(rd), .rd_busy(rd_busy),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .set_busy(set_busy), .set_addr(set_addr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    reg_file_sb #(.DATA_W(64), .ADDR_W(4), .NRD(4)) dut2 (
        .clk(clk), .rst(rst2), .init_done(init_done2),
        .ra(ra2), .rd(rd2), .rd_busy(rd_busy2),
        .we0(we0_2), .wa0(wa0_2), .wd0(wd0_2),
        .we1(we1_2), .wa1(wa1_2), .wd1(wd1_2),
        .set_busy(set_busy2), .set_addr(set_addr2),
        .dbg_addr(dbg_addr2), .dbg_data(dbg_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (!m_ready || a == 5'd0) return '0;
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (!m_ready) return 1'b0;
        return m_busy[a] && !((we1 && wa1 == a) || (we0 && wa0 == a));
    endfunction

    // Effect of one rising edge (rst low) on the model.
    task automatic model_edge();
        if (!m_ready) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_ready = 1'b1;
                foreach (m_mem[i]) m_mem[i] = '0;
            end
        end else begin
            if (we1 && wa1 != 5'd0) begin
                m_mem[wa1] = wd1;
                m_busy[wa1] = 1'b0;
            end
            if (we0 && wa0 != 5'd0 && !(we1 && wa1 == wa0)) begin
                m_mem[wa0] = wd0;
                m_busy[wa0] = 1'b0;
            end
            if (set_busy && set_addr != 5'd0) m_busy[set_addr] = 1'b1;
        end
    endtask

    // Called at posedge+1 with inputs already applied; checks all outputs
    // of the main instance, then advances one clock.
    task automatic cycle();
        logic [4:0] a;
        if (rst) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end
        #2;
        chk("init_done", init_done, m_ready);
        for (int p = 0; p < 3; p++) begin
            a = ra[p*5 +: 5];
            chk($sformatf("rd%0d", p), rd[p*32 +: 32], exp_rd(a));
            chk($sformatf("rd_busy%0d", p), rd_busy[p], exp_busy(a));
        end
        chk("dbg_data", dbg_data, (m_ready && dbg_addr != 5'd0) ? m_mem[dbg_addr] : 32'd0);
        $display("cyc %0d rst=%0b ra=%h we0=%0b wa0=%0d wd0=%h we1=%0b wa1=%0d wd1=%h sb=%0b sa=%0d rd=%h busy=%b",
                 n_cyc, rst, ra, we0, wa0, wd0, we1, wa1, wd1, set_busy, set_addr, rd, rd_busy);
        n_cyc++;
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        set_busy = 1'b0; set_addr = '0;
    endtask

    task automatic wait_init(input int exp, input string tag);
        int n;
        n = 0;
        while (!init_done && n < 100) begin
            cycle();
            n++;
        end
        chk(tag, n, exp);
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        int n;
        rst = 1'b1; idle(); ra = '0; dbg_addr = '0;
        rst2 = 1'b1; ra2 = '0; we0_2 = 1'b0; wa0_2 = '0; wd0_2 = '0;
        we1_2 = 1'b0; wa1_2 = '0; wd1_2 = '0; set_busy2 = 1'b0; set_addr2 = '0; dbg_addr2 = '0;
        m_ready = 1'b0; m_cnt = 0;
        foreach (m_mem[i]) m_mem[i] = '0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        @(posedge clk); #1;
        cycle(); cycle();

        // Clear sweep and read-back of every address.
        rst = 1'b0;
        wait_init(32, "init_lat");
        for (int a = 0; a < DEPTH; a++) begin
            ra = {5'(a), 5'(a), 5'(a)}; dbg_addr = 5'(a);
            cycle();
        end

        // Basic write with bypass; debug port sees it only next cycle.
        idle(); we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra = {5'd0, 5'd0, 5'd5}; dbg_addr = 5'd5;
        #1; chk("bypass_same", rd[31:0], 32'hDEADBEEF); chk("dbg_nobypass", dbg_data, 32'd0);
        cycle();
        idle();
        #1; chk("rd_next", rd[31:0], 32'hDEADBEEF); chk("dbg_next", dbg_data, 32'hDEADBEEF);
        cycle();

        // Port clash on address 7 and writes to register 0.
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'd1; we1 = 1'b1; wa1 = 5'd7; wd1 = 32'd2; ra = {5'd0, 5'd0, 5'd7};
        #1; chk("clash_bypass", rd[31:0], 32'd2);
        cycle();
        idle(); dbg_addr = 5'd7;
        #1; chk("clash_rf", dbg_data, 32'd2);
        cycle();
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1234; ra = '0;
        #1; chk("r0_bypass", rd[31:0], 32'd0);
        cycle();
        idle(); dbg_addr = 5'd0;
        #1; chk("r0_rd", rd[31:0], 32'd0); chk("r0_dbg", dbg_data, 32'd0);
        cycle();

        // Scoreboard set, bypass resolution, clear, set-wins.
        set_busy = 1'b1; set_addr = 5'd9; ra = {5'd0, 5'd0, 5'd9};
        #1; chk("busy_before", rd_busy[0], 1'b0);
        cycle();
        idle();
        #1; chk("busy_set", rd_busy[0], 1'b1);
        cycle();
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99;
        #1; chk("busy_bypass", rd_busy[0], 1'b0);
        cycle();
        idle();
        #1; chk("busy_cleared", rd_busy[0], 1'b0);
        cycle();
        set_busy = 1'b1; set_addr = 5'd9; we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hAA;
        cycle();
        idle();
        #1; chk("busy_set_wins", rd_busy[0], 1'b1);
        cycle();

        // Writes and issue during the sweep are ignored.
        rst = 1'b1; cycle(); rst = 1'b0;
        repeat (9) cycle();
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h55; set_busy = 1'b1; set_addr = 5'd3;
        cycle();
        idle();
        wait_init(22, "init_lat_sweepwr");
        ra = {5'd0, 5'd0, 5'd3}; dbg_addr = 5'd3;
        #1; chk("sweep_rf3", rd[31:0], 32'd0); chk("sweep_busy3", rd_busy[0], 1'b0);
        cycle();

        // Reset in the middle of the sweep restarts it.
        rst = 1'b1; cycle(); rst = 1'b0;
        repeat (20) cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        wait_init(32, "init_lat_restart");

        // Randomised traffic against the model.
        repeat (400) begin
            we0 = ($urandom_range(0, 2) != 0); wa0 = rnd_addr(); wd0 = $urandom;
            we1 = ($urandom_range(0, 2) == 0); wa1 = rnd_addr(); wd1 = $urandom;
            set_busy = ($urandom_range(0, 1) == 0); set_addr = rnd_addr();
            ra = {rnd_addr(), rnd_addr(), rnd_addr()}; dbg_addr = rnd_addr();
            cycle();
        end
        idle();

        // Second configuration: 16-entry sweep and bypass on all 4 ports.
        rst2 = 1'b0;
        n = 0;
        while (!init_done2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("init_lat2", n, 16);
        ra2 = {4'd4, 4'd3, 4'd2, 4'd1};
        we1_2 = 1'b1; wa1_2 = 4'd2; wd1_2 = 64'h1111_2222_3333_4444;
        we0_2 = 1'b1; wa0_2 = 4'd3; wd0_2 = 64'hAAAA_BBBB_CCCC_DDDD;
        #1;
        chk("p4_rd0_a", rd2[63:0], 64'd0);
        chk("p4_rd1_a", rd2[127:64], 64'h1111_2222_3333_4444);
        chk("p4_rd2_a", rd2[191:128], 64'hAAAA_BBBB_CCCC_DDDD);
        chk("p4_rd3_a", rd2[255:192], 64'd0);
        @(posedge clk); #1;
        we1_2 = 1'b1; wa1_2 = 4'd4; wd1_2 = 64'h0123_4567_89AB_CDEF;
        we0_2 = 1'b1; wa0_2 = 4'd1; wd0_2 = 64'hFEDC_BA98_7654_3210;
        #1;
        chk("p4_rd0_b", rd2[63:0], 64'hFEDC_BA98_7654_3210);
        chk("p4_rd1_b", rd2[127:64], 64'h1111_2222_3333_4444);
        chk("p4_rd2_b", rd2[191:128], 64'hAAAA_BBBB_CCCC_DDDD);
        chk("p4_rd3_b", rd2[255:192], 64'h0123_4567_89AB_CDEF);
        @(posedge clk); #1;
        we0_2 = 1'b0; we1_2 = 1'b0;
        #1;
        chk("p4_rd0_c", rd2[63:0], 64'hFEDC_BA98_7654_3210);
        chk("p4_rd3_c", rd2[255:192], 64'h0123_4567_89AB_CDEF);
        $display("dut2 bypass sequence done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
